// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and tag encodings for the common data bus.
// Values mirror defines.v so every CDB consumer agrees on the tag format.
package cdb_arbiter_pkg;

  localparam int unsigned Data_Width      = 32;
  localparam int unsigned ROB_Entry_Width = 4;
  localparam int unsigned Reg_Lock_Width  = 5;

  // Tag value meaning "no producer"; a zero-extended ROB index never has the top bit set.
  localparam logic [Reg_Lock_Width-1:0] Reg_No_Lock = 5'b1_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  int unsigned j;

  // Scan upward from ptr modulo N and take the first active request.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (en && !any && req[PW'(j)]) begin
        gnt[PW'(j)] = 1'b1;
        gnt_idx     = PW'(j);
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one function-unit result per cycle (round robin)
// and broadcasts the winner's ROB tag and data on the following cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_valid,
  input  logic [N_REQ*ROB_Entry_Width-1:0]   req_index,
  input  logic [N_REQ*Data_Width-1:0]        req_result,
  input  logic                               hold,
  input  logic                               flush,
  output logic [N_REQ-1:0]                   grnt,
  output logic [Reg_Lock_Width-1:0]          cdb_in_index,
  output logic [Data_Width-1:0]              cdb_in_result,
  output logic                               cdb_valid
);

  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           gnt_idx;
  logic                       gnt_any;
  logic [ROB_Entry_Width-1:0] sel_index;
  logic [Data_Width-1:0]      sel_result;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PTR_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (!hold && !flush),
    .gnt     (grnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // One-hot AND-OR select of the granted requester's packed slices.
  always_comb begin
    sel_index  = '0;
    sel_result = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grnt[i]) begin
        sel_index  = sel_index  | req_index[i*ROB_Entry_Width +: ROB_Entry_Width];
        sel_result = sel_result | req_result[i*Data_Width +: Data_Width];
      end
    end
  end

  // Broadcast registers and round-robin pointer; flush idles the bus and rewinds the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_in_index  <= Reg_No_Lock;
      cdb_in_result <= '0;
      cdb_valid     <= 1'b0;
      rr_ptr        <= '0;
    end else if (flush) begin
      cdb_in_index  <= Reg_No_Lock;
      cdb_valid     <= 1'b0;
      rr_ptr        <= '0;
    end else if (gnt_any) begin
      cdb_in_index  <= Reg_Lock_Width'(sel_index);
      cdb_in_result <= sel_result;
      cdb_valid     <= 1'b1;
      rr_ptr        <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else begin
      // Result data holds while idle; only the tag marks the bus empty.
      cdb_in_index  <= Reg_No_Lock;
      cdb_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic
// compared against a round-robin reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 4;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [N-1:0]                  req_valid;
  logic [N*ROB_Entry_Width-1:0]  req_index;
  logic [N*Data_Width-1:0]       req_result;
  logic                          hold;
  logic                          flush;
  logic [N-1:0]                  grnt;
  logic [Reg_Lock_Width-1:0]     cdb_in_index;
  logic [Data_Width-1:0]         cdb_in_result;
  logic                          cdb_valid;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int                        m_ptr;
  logic [Reg_Lock_Width-1:0] m_idx;
  logic [Data_Width-1:0]     m_res;
  logic                      m_valid;

  cdb_arbiter #(
    .N_REQ (N),
    .PTR_W (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_index     (req_index),
    .req_result    (req_result),
    .hold          (hold),
    .flush         (flush),
    .grnt          (grnt),
    .cdb_in_index  (cdb_in_index),
    .cdb_in_result (cdb_in_result),
    .cdb_valid     (cdb_valid)
  );

  always #5 clk = ~clk;

  function automatic int model_grant();
    if (hold || flush) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] gvec(int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_idx   = Reg_No_Lock;
    m_res   = '0;
    m_valid = 1'b0;
  endtask

  task automatic set_req(int fu, logic [ROB_Entry_Width-1:0] idx, logic [Data_Width-1:0] res);
    req_valid[fu]                                   = 1'b1;
    req_index[fu*ROB_Entry_Width +: ROB_Entry_Width] = idx;
    req_result[fu*Data_Width +: Data_Width]          = res;
  endtask

  // Advance one clock edge and update the model; returns 1ns after the edge.
  task automatic tick();
    int g;
    g = model_grant();
    @(posedge clk);
    if (flush) begin
      m_idx   = Reg_No_Lock;
      m_valid = 1'b0;
      m_ptr   = 0;
    end else if (g >= 0) begin
      m_idx   = Reg_Lock_Width'(req_index[g*ROB_Entry_Width +: ROB_Entry_Width]);
      m_res   = req_result[g*Data_Width +: Data_Width];
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
    end else begin
      m_idx   = Reg_No_Lock;
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_index = '0; req_result = '0; hold = 1'b0; flush = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    vectors++;
    if (cdb_valid !== 1'b0 || cdb_in_index !== Reg_No_Lock || cdb_in_result !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b idx=%h res=%h, want 0/%h/0",
               cdb_valid, cdb_in_index, cdb_in_result, Reg_No_Lock);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (grnt !== '0) begin
        errors++;
        $display("FAIL reset_idle_grnt c%0d: got %b want 0000", c, grnt);
      end
      tick();
      vectors++;
      if (cdb_valid !== 1'b0 || cdb_in_index !== Reg_No_Lock) begin
        errors++;
        $display("FAIL reset_idle c%0d: valid=%b idx=%h want 0/%h", c, cdb_valid, cdb_in_index,
                 Reg_No_Lock);
      end
    end
  endtask

  task automatic test_single();
    set_req(1, 4'd5, 32'hDEAD_BEEF);
    #1;
    vectors++;
    if (grnt !== 4'b0010) begin
      errors++;
      $display("FAIL single_grnt: got %b want 0010", grnt);
    end
    tick();
    req_valid = '0;
    vectors++;
    if (cdb_in_index !== 5'd5 || cdb_in_result !== 32'hDEAD_BEEF || cdb_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_bcast: idx=%h res=%h valid=%b want 05/deadbeef/1",
               cdb_in_index, cdb_in_result, cdb_valid);
    end
    tick();
    vectors++;
    if (cdb_valid !== 1'b0 || cdb_in_index !== Reg_No_Lock || cdb_in_result !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_idle: idx=%h res=%h valid=%b want %h/deadbeef/0",
               cdb_in_index, cdb_in_result, cdb_valid, Reg_No_Lock);
    end
  endtask

  task automatic test_back_to_back();
    // Rewind the pointer with a flush cycle first.
    flush = 1'b1; req_valid = '0;
    tick();
    flush = 1'b0;
    for (int fu = 0; fu < N; fu++) set_req(fu, 4'(fu + 8), 32'hA000_0000 + 32'(fu));
    for (int c = 0; c < 8; c++) begin
      #1;
      vectors++;
      if (grnt !== gvec(c % N)) begin
        errors++;
        $display("FAIL b2b_grnt c%0d: got %b want %b", c, grnt, gvec(c % N));
      end
      tick();
      vectors++;
      if (cdb_valid !== 1'b1 || cdb_in_index !== 5'(c % N + 8) ||
          cdb_in_result !== 32'hA000_0000 + 32'(c % N)) begin
        errors++;
        $display("FAIL b2b_bcast c%0d: idx=%h res=%h valid=%b want %h/%h/1", c, cdb_in_index,
                 cdb_in_result, cdb_valid, 5'(c % N + 8), 32'hA000_0000 + 32'(c % N));
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_hold();
    set_req(2, 4'd3, 32'h1234_5678);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (grnt !== '0) begin
        errors++;
        $display("FAIL hold_grnt c%0d: got %b want 0000", c, grnt);
      end
      tick();
      vectors++;
      if (cdb_valid !== 1'b0 || cdb_in_index !== Reg_No_Lock) begin
        errors++;
        $display("FAIL hold_idle c%0d: valid=%b idx=%h", c, cdb_valid, cdb_in_index);
      end
    end
    hold = 1'b0;
    #1;
    vectors++;
    if (grnt !== 4'b0100) begin
      errors++;
      $display("FAIL hold_release_grnt: got %b want 0100", grnt);
    end
    tick();
    req_valid = '0;
    vectors++;
    if (cdb_valid !== 1'b1 || cdb_in_index !== 5'd3 || cdb_in_result !== 32'h1234_5678) begin
      errors++;
      $display("FAIL hold_release_bcast: idx=%h res=%h valid=%b", cdb_in_index, cdb_in_result,
               cdb_valid);
    end
  endtask

  task automatic test_flush();
    req_valid = '0;
    set_req(2, 4'd7, 32'h0000_0777);
    tick();
    req_valid = '0;
    set_req(0, 4'd1, 32'h0000_0111);
    set_req(3, 4'd2, 32'h0000_0222);
    flush = 1'b1;
    #1;
    vectors++;
    if (grnt !== '0) begin
      errors++;
      $display("FAIL flush_grnt: got %b want 0000", grnt);
    end
    vectors++;
    if (cdb_valid !== 1'b1 || cdb_in_index !== 5'd7) begin
      errors++;
      $display("FAIL flush_cycle_bcast: idx=%h valid=%b want 07/1", cdb_in_index, cdb_valid);
    end
    tick();
    flush = 1'b0;
    vectors++;
    if (cdb_valid !== 1'b0 || cdb_in_index !== Reg_No_Lock) begin
      errors++;
      $display("FAIL flush_idle: idx=%h valid=%b", cdb_in_index, cdb_valid);
    end
    #1;
    vectors++;
    if (grnt !== 4'b0001) begin
      errors++;
      $display("FAIL flush_ptr_rewind: got %b want 0001", grnt);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_async_reset();
    req_valid = '0;
    set_req(3, 4'd9, 32'hCAFE_F00D);
    tick();
    req_valid = '0;
    vectors++;
    if (cdb_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: valid=%b want 1", cdb_valid);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (cdb_valid !== 1'b0 || cdb_in_index !== Reg_No_Lock || cdb_in_result !== '0) begin
      errors++;
      $display("FAIL areset_idle: idx=%h res=%h valid=%b", cdb_in_index, cdb_in_result, cdb_valid);
    end
    #1 rst = 1'b0;
    for (int fu = 0; fu < N; fu++) set_req(fu, 4'(fu), 32'(fu));
    #1;
    vectors++;
    if (grnt !== 4'b0001) begin
      errors++;
      $display("FAIL areset_ptr: got %b want 0001", grnt);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid  = 4'($urandom_range(0, 15));
      req_index  = 16'($urandom);
      req_result = {$urandom, $urandom, $urandom, $urandom};
      hold       = ($urandom_range(0, 4) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      #1;
      vectors++;
      if (grnt !== gvec(model_grant())) begin
        errors++;
        $display("FAIL rand_grnt c%0d: got %b want %b", c, grnt, gvec(model_grant()));
      end
      tick();
      vectors++;
      if (cdb_valid !== m_valid || cdb_in_index !== m_idx || cdb_in_result !== m_res) begin
        errors++;
        $display("FAIL rand_bcast c%0d: idx=%h res=%h valid=%b want %h/%h/%b", c, cdb_in_index,
                 cdb_in_result, cdb_valid, m_idx, m_res, m_valid);
      end
    end
    hold = 1'b0; flush = 1'b0; req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
